switch_input_port: RTL and testbench

SWITCH_INPUT_PORT -- requirements
Module: switch_input_port

---
 rtl/switch_input_port.sv | 236 +++++++++++++++++++++++
 tb/tb_switch_input_port.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_port.sv
// -----------------------------------------------------------------------------
// switch_input_port
//
// Three-switch input block. Each raw switch level is synchronised, debounced
// and turned into a press event on its debounced rising edge. Events are
// queued in a small FIFO that the CPU drains through a 4-entry read map.
// irq is high while the FIFO holds anything.
//
// Ports
//   clk       in   1  single clock, everything updates on its rising edge
//   reset     in   1  synchronous, active-high reset
//   i_sw      in   3  raw asynchronous switch levels, active high
//   rd_en     in   1  CPU read strobe, one cycle per access
//   rd_addr   in   2  register select while rd_en=1
//   rd_data   out  8  read data, registered, valid when rd_valid=1, held otherwise
//   rd_valid  out  1  one-cycle pulse, one cycle after each rd_en
//   irq       out  1  high while the event FIFO is non-empty
//
// Read map
//   0 : {5'b0, debounced[2:0]}
//   1 : {overflow, 2'b0, occupancy[4:0]}   (clears overflow; a same-cycle set wins)
//   2 : FIFO head, pops one entry; 8'h00 and no pop when empty
//   3 : press counter (accepted pushes, wraps)
// -----------------------------------------------------------------------------
module switch_input_port #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_sw,
    input  logic       rd_en,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // The counter reaching CNT_LAST while still mismatched marks the
    // DEBOUNCE_CYCLES-th consecutive mismatch cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_deb;
    logic [2:0]       r_pend;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_ovf;
    logic [7:0]       r_press;

    logic [7:0]       r_rd_data;
    logic             r_rd_valid;
    logic             r_irq;

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt_d [3];
    logic [2:0]       w_deb_d;
    logic [2:0]       w_rise;

    logic             w_push_valid;
    logic [1:0]       w_push_idx;
    logic [2:0]       w_pend_clr;
    logic [7:0]       w_push_entry;

    logic             w_rd_fifo;
    logic             w_rd_stat;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;
    logic [OCC_W-1:0] w_occ_d;
    logic [4:0]       w_occ5;
    logic [7:0]       w_rd_mux;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronised level
    // disagrees with the debounced level; any agreement restarts at 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_deb_d = r_deb;
        w_rise  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_cnt_d[i] = '0;
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_deb_d[i] = r_sync2[i];
                    // only 0->1 transitions raise an event
                    w_rise[i]  = r_sync2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Push arbitration: lowest-index pending switch wins, one per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_push_valid = |r_pend;
        w_push_idx   = 2'd0;
        w_pend_clr   = 3'b000;
        if (r_pend[0]) begin
            w_push_idx = 2'd0;
            w_pend_clr = 3'b001;
        end else if (r_pend[1]) begin
            w_push_idx = 2'd1;
            w_pend_clr = 3'b010;
        end else if (r_pend[2]) begin
            w_push_idx = 2'd2;
            w_pend_clr = 3'b100;
        end
    end

    assign w_push_entry = {1'b1, 5'b00000, w_push_idx};

    // ------------------------------------------------------------------
    // FIFO control. A pop frees a slot in the same cycle, so a push onto
    // a full FIFO is accepted when it coincides with a pop.
    // ------------------------------------------------------------------
    assign w_rd_fifo = rd_en && (rd_addr == 2'd2);
    assign w_rd_stat = rd_en && (rd_addr == 2'd1);
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OCC_FULL);
    assign w_pop     = w_rd_fifo && !w_empty;
    assign w_push_ok = w_push_valid && (!w_full || w_pop);
    assign w_drop    = w_push_valid && w_full && !w_pop;

    always_comb begin
        w_occ_d = r_occ;
        if (w_push_ok && !w_pop) begin
            w_occ_d = r_occ + OCC_W'(1);
        end else if (w_pop && !w_push_ok) begin
            w_occ_d = r_occ - OCC_W'(1);
        end
    end

    assign w_occ5 = 5'(r_occ);

    // ------------------------------------------------------------------
    // Read mux, sampled into r_rd_data on the rd_en cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 8'h00;
        unique case (rd_addr)
            2'd0: w_rd_mux = {5'b00000, r_deb};
            2'd1: w_rd_mux = {r_ovf, 2'b00, w_occ5};
            2'd2: w_rd_mux = w_empty ? 8'h00 : r_mem[r_rd_ptr];
            2'd3: w_rd_mux = r_press;
            default: w_rd_mux = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 3'b000;
            r_sync2    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
            r_deb      <= 3'b000;
            r_pend     <= 3'b000;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_ovf      <= 1'b0;
            r_press    <= 8'h00;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_deb <= w_deb_d;

            // A rise on a still-pending switch simply merges into the set bit.
            r_pend <= (r_pend & ~w_pend_clr) | w_rise;

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_press  <= r_press + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ <= w_occ_d;
            r_irq <= (w_occ_d != '0);

            // A drop in the same cycle as a status read keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_rd_stat) begin
                r_ovf <= 1'b0;
            end

            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

endmodule

// File: tb/tb_switch_input_port.sv
// -----------------------------------------------------------------------------
// tb_switch_input_port
//
// Scoreboard bench for switch_input_port (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// A behavioural model tracks debounced levels, the event queue, overflow and
// the press count at the level of whole presses; each read pushes its expected
// data into a queue that a negedge monitor drains against rd_valid/rd_data.
// -----------------------------------------------------------------------------
module tb_switch_input_port;

    localparam int DEB    = 4;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] i_sw;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [2:0] m_lvl;
    logic [7:0] m_fifo[$];
    logic       m_ovf;
    logic [7:0] m_press;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp;

    always #5 clk = ~clk;

    switch_input_port #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_sw    (i_sw),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .irq     (irq)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_lvl   = 3'b000;
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_press = 8'h00;
    endfunction

    function automatic void model_push(int idx);
        if (m_fifo.size() < DEPTH) begin
            m_fifo.push_back(8'h80 | 8'(idx));
            m_press = m_press + 8'd1;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    // Apply whatever the switches now show, once it has been stable long enough.
    function automatic void model_settle();
        for (int i = 0; i < 3; i++) begin
            if (i_sw[i] && !m_lvl[i]) model_push(i);
        end
        m_lvl = i_sw;
    endfunction

    // Monitor: every rd_valid must match the oldest expected read.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            last_exp = 8'h00;
        end else if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%0h, no read outstanding",
                         rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e));
                last_exp = e;
            end
        end else begin
            check("rd_data_hold", 32'(rd_data), 32'(last_exp));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic set_sw(input logic [2:0] v);
        @(posedge clk);
        #1;
        i_sw = v;
        repeat (SETTLE) @(posedge clk);
        #1;
        model_settle();
        check("irq_after_settle", 32'(irq), 32'(m_fifo.size() != 0));
    endtask

    // Must be entered just after a rising edge; leaves just after the next one.
    task automatic issue_read(input logic [1:0] addr);
        logic [7:0] e;
        case (addr)
            2'd0: e = {5'b00000, m_lvl};
            2'd1: begin
                e = {m_ovf, 2'b00, 5'(m_fifo.size())};
                m_ovf = 1'b0;
            end
            2'd2: e = (m_fifo.size() > 0) ? m_fifo.pop_front() : 8'h00;
            default: e = m_press;
        endcase
        exp_q.push_back(e);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        i_sw    = 3'b000;
        rd_en   = 1'b0;
        rd_addr = 2'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_irq", 32'(irq), 32'(0));
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rd_data", 32'(rd_data), 32'(0));
        for (int a = 0; a < 4; a++) issue_read(2'(a));

        // Bounce on switch 1: 2-cycle runs never reach the debounce count
        for (int k = 0; k < 10; k++) begin
            i_sw[1] = ~i_sw[1];
            repeat (2) @(posedge clk);
            #1;
        end
        set_sw(3'b010);
        check("bounce_irq", 32'(irq), 32'(1));
        issue_read(2'd3);
        issue_read(2'd0);
        issue_read(2'd2);
        issue_read(2'd2);

        // Simultaneous press: order 80, 81, 82 then empty
        i_sw = 3'b000;
        do_reset();
        set_sw(3'b111);
        for (int k = 0; k < 4; k++) issue_read(2'd2);
        check("simul_irq_empty", 32'(irq), 32'(0));

        // Overflow: five presses, no reads
        i_sw = 3'b000;
        do_reset();
        set_sw(3'b001);
        set_sw(3'b011);
        set_sw(3'b111);
        set_sw(3'b000);
        set_sw(3'b001);
        set_sw(3'b000);
        set_sw(3'b001);
        issue_read(2'd1);
        issue_read(2'd1);
        issue_read(2'd3);
        for (int k = 0; k < 5; k++) issue_read(2'd2);

        // Full plus pop: switch 1 push lands on the same edge as an addr 2 pop.
        // Push edge = 2 sync + DEB mismatch cycles + 1 pending stage after the change.
        i_sw = 3'b000;
        do_reset();
        set_sw(3'b111);
        set_sw(3'b000);
        set_sw(3'b001);
        check("full_irq", 32'(irq), 32'(1));
        @(posedge clk);
        #1;
        i_sw = 3'b011;
        repeat (2 + DEB) @(posedge clk);
        #1;
        issue_read(2'd2);
        repeat (SETTLE) @(posedge clk);
        #1;
        model_settle();
        issue_read(2'd1);
        for (int k = 0; k < 5; k++) issue_read(2'd2);
        issue_read(2'd3);

        // Reset mid-operation with two entries queued and switch 0 mid-debounce
        i_sw = 3'b000;
        do_reset();
        set_sw(3'b110);
        @(posedge clk);
        #1;
        i_sw = 3'b111;
        repeat (4) @(posedge clk);
        do_reset();
        check("midreset_irq", 32'(irq), 32'(0));
        issue_read(2'd1);
        issue_read(2'd0);
        // Switches held through reset debounce again and raise fresh events
        set_sw(3'b111);
        for (int k = 0; k < 4; k++) issue_read(2'd2);

        // Randomised mix of switch changes and read bursts
        i_sw = 3'b000;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_sw(3'($urandom_range(0, 7)));
            end else begin
                int burst;
                burst = $urandom_range(1, 3);
                for (int b = 0; b < burst; b++) issue_read(2'($urandom_range(0, 3)));
            end
        end

        // Press counter wrap on switch 2
        i_sw = 3'b000;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            set_sw(3'b100);
            issue_read(2'd2);
            set_sw(3'b000);
        end
        issue_read(2'd3);
        issue_read(2'd1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
